// File: rtl/wb_pkg.sv
// Writeback-stage shared definitions.
// Holds the data/register/control widths and the bit positions of the
// 7-bit WB control word. The decode stage imports this package to build
// iWB, so any change to the bit layout lands in both stages at once.
package wb_pkg;

    localparam int DW = 32;  // data word width
    localparam int RW = 6;   // register index width (64 registers)
    localparam int CW = 7;   // WB control width

    // WB control word bit positions
    localparam int WB_REGWE  = 0;
    localparam int WB_SELMEM = 1;
    localparam int WB_SELIMM = 2;
    localparam int WB_FLAGWE = 3;
    localparam int WB_BRZ    = 4;
    localparam int WB_BRN    = 5;
    localparam int WB_JUMP   = 6;

    // One retired register write, as seen by the EX-stage forwarding logic
    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } fwd_ent_t;

endpackage

// File: rtl/wb_fwd_hist.sv
// Two-entry history of retired register writes.
// A push moves entry 0 into entry 1 and loads the new write into entry 0.
// Without a push, or while held, both entries keep their contents.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   hold         : freeze both entries
//   push         : a register write retires this cycle
//   rd, data     : destination and value of that write
//   ent0, ent1   : most recent / previous retired write
module wb_fwd_hist
    import wb_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          hold,
    input  logic          push,
    input  logic [RW-1:0] rd,
    input  logic [DW-1:0] data,
    output fwd_ent_t      ent0,
    output fwd_ent_t      ent1
);

    always_ff @(posedge clock) begin
        if (reset) begin
            ent0 <= '0;
            ent1 <= '0;
        end else if (!hold && push) begin
            ent1 <= ent0;
            ent0 <= '{v: 1'b1, rd: rd, data: data};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage.
// Selects the writeback value (memory > immediate > ALU), drives a
// registered register-file write port, owns the architectural N/Z flags,
// resolves branch/jump redirects, keeps a 2-deep forwarding history and
// counts retired (non-bubble) instructions. All outputs are registered.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   iDMEM, iALU, iI     : memory word, ALU result, immediate/branch target
//   iRd, iWB, iN, iZ    : destination, WB control (0 = bubble), EX flags
//   iHold               : freeze the stage this cycle
//   rf_we/waddr/wdata   : register file write port
//   flagN, flagZ        : architectural flags
//   pc_redirect/target  : branch/jump taken and its target
//   fwd0_*, fwd1_*      : most recent / previous retired write
//   retired             : retired instruction count (wraps)
module wb_stage
    import wb_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] iDMEM,
    input  logic [DW-1:0] iALU,
    input  logic [DW-1:0] iI,
    input  logic [RW-1:0] iRd,
    input  logic [CW-1:0] iWB,
    input  logic          iN,
    input  logic          iZ,
    input  logic          iHold,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          flagN,
    output logic          flagZ,
    output logic          pc_redirect,
    output logic [DW-1:0] pc_target,
    output logic          fwd0_v,
    output logic [RW-1:0] fwd0_rd,
    output logic [DW-1:0] fwd0_data,
    output logic          fwd1_v,
    output logic [RW-1:0] fwd1_rd,
    output logic [DW-1:0] fwd1_data,
    output logic [31:0]   retired
);

    logic [DW-1:0] wb_val;
    logic          taken;
    fwd_ent_t      ent0, ent1;

    always_comb begin
        wb_val = iALU;
        if (iWB[WB_SELMEM])      wb_val = iDMEM;
        else if (iWB[WB_SELIMM]) wb_val = iI;
    end

    // Branches test the flag register as it stands before this
    // instruction's own flag update lands.
    assign taken = iWB[WB_JUMP]
                 | (iWB[WB_BRZ] & flagZ)
                 | (iWB[WB_BRN] & flagN);

    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            flagN       <= 1'b0;
            flagZ       <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= '0;
            retired     <= '0;
        end else if (iHold) begin
            // Strobes drop while frozen; everything else keeps its value.
            rf_we       <= 1'b0;
            pc_redirect <= 1'b0;
        end else begin
            rf_we       <= iWB[WB_REGWE];
            pc_redirect <= taken;
            if (iWB[WB_REGWE]) begin
                rf_waddr <= iRd;
                rf_wdata <= wb_val;
            end
            if (iWB[WB_FLAGWE]) begin
                flagN <= iN;
                flagZ <= iZ;
            end
            if (taken) pc_target <= iI;
            if (iWB != '0) retired <= retired + 32'd1;
        end
    end

    wb_fwd_hist u_hist (
        .clock (clock),
        .reset (reset),
        .hold  (iHold),
        .push  (iWB[WB_REGWE]),
        .rd    (iRd),
        .data  (wb_val),
        .ent0  (ent0),
        .ent1  (ent1)
    );

    assign fwd0_v    = ent0.v;
    assign fwd0_rd   = ent0.rd;
    assign fwd0_data = ent0.data;
    assign fwd1_v    = ent1.v;
    assign fwd1_rd   = ent1.rd;
    assign fwd1_data = ent1.data;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps from the test plan followed by a
// randomized run, each cycle compared against an instruction-level model.
module tb_wb_stage;
    import wb_pkg::*;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] iDMEM, iALU, iI;
    logic [RW-1:0] iRd;
    logic [CW-1:0] iWB;
    logic          iN, iZ, iHold;
    logic          rf_we, flagN, flagZ, pc_redirect, fwd0_v, fwd1_v;
    logic [RW-1:0] rf_waddr, fwd0_rd, fwd1_rd;
    logic [DW-1:0] rf_wdata, pc_target, fwd0_data, fwd1_data;
    logic [31:0]   retired;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    wb_stage dut (
        .clock(clock), .reset(reset), .iDMEM(iDMEM), .iALU(iALU), .iI(iI),
        .iRd(iRd), .iWB(iWB), .iN(iN), .iZ(iZ), .iHold(iHold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flagN(flagN), .flagZ(flagZ), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .fwd0_v(fwd0_v), .fwd0_rd(fwd0_rd),
        .fwd0_data(fwd0_data), .fwd1_v(fwd1_v), .fwd1_rd(fwd1_rd),
        .fwd1_data(fwd1_data), .retired(retired)
    );

    // Reference model: architectural state after each instruction.
    typedef struct { logic [RW-1:0] rd; logic [DW-1:0] data; } wr_t;
    wr_t           hist[$];   // retired writes, newest first
    logic          m_we, m_redir, m_n, m_z;
    logic [RW-1:0] m_waddr;
    logic [DW-1:0] m_wdata, m_target;
    logic [31:0]   m_ret;

    function automatic void model_reset();
        hist.delete();
        m_we = 0; m_redir = 0; m_n = 0; m_z = 0;
        m_waddr = '0; m_wdata = '0; m_target = '0; m_ret = '0;
    endfunction

    function automatic void model_step();
        logic [DW-1:0] val;
        logic          br;
        if (reset) begin
            model_reset();
            return;
        end
        if (iHold) begin
            m_we = 0;
            m_redir = 0;
            return;
        end
        val = iWB[1] ? iDMEM : (iWB[2] ? iI : iALU);
        br  = iWB[6] || (iWB[4] && m_z) || (iWB[5] && m_n);
        m_we = iWB[0];
        m_redir = br;
        if (br) m_target = iI;
        if (iWB[0]) begin
            m_waddr = iRd;
            m_wdata = val;
            hist.push_front('{rd: iRd, data: val});
            if (hist.size() > 2) hist.pop_back();
        end
        if (iWB[3]) begin
            m_n = iN;
            m_z = iZ;
        end
        if (iWB != 0) m_ret = m_ret + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic          e0v, e1v;
        logic [RW-1:0] e0r, e1r;
        logic [DW-1:0] e0d, e1d;
        e0v = hist.size() > 0; e0r = e0v ? hist[0].rd : '0; e0d = e0v ? hist[0].data : '0;
        e1v = hist.size() > 1; e1r = e1v ? hist[1].rd : '0; e1d = e1v ? hist[1].data : '0;
        chk("rf_we",       64'(rf_we),       64'(m_we));
        chk("rf_waddr",    64'(rf_waddr),    64'(m_waddr));
        chk("rf_wdata",    64'(rf_wdata),    64'(m_wdata));
        chk("flagN",       64'(flagN),       64'(m_n));
        chk("flagZ",       64'(flagZ),       64'(m_z));
        chk("pc_redirect", 64'(pc_redirect), 64'(m_redir));
        chk("pc_target",   64'(pc_target),   64'(m_target));
        chk("fwd0_v",      64'(fwd0_v),      64'(e0v));
        chk("fwd0_rd",     64'(fwd0_rd),     64'(e0r));
        chk("fwd0_data",   64'(fwd0_data),   64'(e0d));
        chk("fwd1_v",      64'(fwd1_v),      64'(e1v));
        chk("fwd1_rd",     64'(fwd1_rd),     64'(e1r));
        chk("fwd1_data",   64'(fwd1_data),   64'(e1d));
        chk("retired",     64'(retired),     64'(m_ret));
    endtask

    // Apply the current inputs across one rising edge, then compare.
    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [CW-1:0] wb, input logic [RW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                         input logic [DW-1:0] imm, input logic n, input logic z,
                         input logic hold);
        iWB = wb; iRd = rd; iALU = alu; iDMEM = mem; iI = imm;
        iN = n; iZ = z; iHold = hold;
    endtask

    initial begin
        model_reset();
        reset = 1;
        drive('0, '0, '0, '0, '0, 0, 0, 0);
        step();
        step();
        reset = 0;
        step();
        chk("reset_retired", 64'(retired), 64'd0);
        chk("reset_we",      64'(rf_we),   64'd0);

        // Simple ALU write
        drive(7'b0000001, 6'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
        step();
        chk("alu_wdata", 64'(rf_wdata), 64'h1234);
        chk("alu_waddr", 64'(rf_waddr), 64'd5);
        chk("alu_ret",   64'(retired),  64'd1);

        // Memory has priority over immediate
        drive(7'b0000111, 6'd7, 32'h1, 32'hAAAA, 32'hBBBB, 0, 0, 0);
        step();
        chk("mem_prio", 64'(rf_wdata), 64'hAAAA);

        // Flag write, then branch-on-Z with a simultaneous flag update
        drive(7'b0001000, 6'd0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        step();
        chk("flagZ_set", 64'(flagZ), 64'd1);
        drive(7'b0011000, 6'd0, 32'h0, 32'h0, 32'h40, 0, 0, 0);
        step();
        chk("br_taken",  64'(pc_redirect), 64'd1);
        chk("br_target", 64'(pc_target),   64'h40);
        chk("flagZ_clr", 64'(flagZ),       64'd0);

        // Held jump+write does nothing, then proceeds once released
        drive(7'b1000001, 6'd9, 32'h99, 32'h0, 32'h80, 0, 0, 1);
        step();
        chk("hold_we",  64'(rf_we),       64'd0);
        chk("hold_br",  64'(pc_redirect), 64'd0);
        chk("hold_ret", 64'(retired),     64'd4);
        iHold = 0;
        step();
        chk("rel_we",  64'(rf_we),       64'd1);
        chk("rel_br",  64'(pc_redirect), 64'd1);
        chk("rel_tgt", 64'(pc_target),   64'h80);

        // Bubble
        drive('0, 6'd3, 32'h5, 32'h6, 32'h7, 1, 1, 0);
        step();
        chk("bubble_we", 64'(rf_we), 64'd0);

        // Forwarding history over three writes
        for (int r = 1; r <= 3; r++) begin
            drive(7'b0000001, RW'(r), 32'h100 + DW'(r), 32'h0, 32'h0, 0, 0, 0);
            step();
        end
        chk("fwd0_rd3", 64'(fwd0_rd), 64'd3);
        chk("fwd1_rd2", 64'(fwd1_rd), 64'd2);

        // Reset mid-sequence with a write and hold in flight
        drive(7'b1111111, 6'd4, 32'h1, 32'h2, 32'h3, 1, 1, 1);
        reset = 1;
        step();
        chk("midrst_ret",  64'(retired), 64'd0);
        chk("midrst_fwd0", 64'(fwd0_v),  64'd0);
        reset = 0;

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom),
                  RW'($urandom), $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
